// File: rtl/mem_stage_cache_pkg.sv
// Shared types and constants for the MEM-stage data cache.
package mem_stage_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte-offset bits of an address; the cache is word-aligned only.
    localparam int BYTE_W = 2;

endpackage

// File: rtl/mem_stage_cache_data_array.sv
// Valid/tag/data storage for the direct-mapped cache: async read, sync write.
module mem_stage_cache_data_array #(
    parameter int DATA_W = 32,
    parameter int LINES  = 4,
    parameter int WPL    = 2,
    parameter int TAG_W  = 27,
    parameter int IDX_W  = 2,
    parameter int OFF_W  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              clr_en
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES][WPL];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx][rd_off];

    // NOTE: only the valid bits are reset; tag/data RAM contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) data_arr[wr_idx][wr_off] <= wr_data;
        if (tag_en) tag_arr[wr_idx] <= wr_tag;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clr_en) begin
            valid[wr_idx] <= 1'b0;
        end else if (tag_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_cache.sv
// Pipeline MEM stage with a direct-mapped, write-through, no-write-allocate data cache.
module mem_stage_cache
    import mem_stage_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LINES  = 4,
    parameter int WPL    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              zero,
    input  logic              branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] aluRslt,
    input  logic [DATA_W-1:0] datafrmreg,
    output logic              hit,
    output logic              stall,
    output logic              pcSrc,
    output logic [DATA_W-1:0] readdata,
    output logic [ADDR_W-1:0] aluRsltt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W   = $clog2(WPL);
    localparam int IDX_W   = $clog2(LINES);
    localparam int OW      = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_LSB = BYTE_W + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    state_t state, next_state;
    logic [OW-1:0] beat_cnt;

    logic [IDX_W-1:0]  a_idx, m_idx;
    logic [OW-1:0]     a_off;
    logic [TAG_W-1:0]  a_tag, m_tag;
    logic              rd_valid, line_hit, last_beat, is_idle;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;

    logic              wr_en, tag_en, clr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [OW-1:0]     wr_off;
    logic [DATA_W-1:0] wr_data;

    // Lookup fields come from the pipeline address; fill fields from the outstanding request.
    assign a_idx = IDX_W'(aluRslt >> IDX_LSB);
    assign a_off = OW'((aluRslt >> BYTE_W) & ADDR_W'(WPL - 1));
    assign a_tag = TAG_W'(aluRslt >> TAG_LSB);
    assign m_idx = IDX_W'(mem_addr >> IDX_LSB);
    assign m_tag = TAG_W'(mem_addr >> TAG_LSB);

    assign line_hit  = rd_valid && (rd_tag == a_tag);
    assign last_beat = (beat_cnt == OW'(WPL - 1));
    assign is_idle   = (state == IDLE);

    assign pcSrc    = branch & zero;
    assign aluRsltt = aluRslt;

    mem_stage_cache_data_array #(
        .DATA_W (DATA_W),
        .LINES  (LINES),
        .WPL    (WPL),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OW)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (a_idx),
        .rd_off   (a_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .tag_en   (tag_en),
        .wr_tag   (m_tag),
        .clr_en   (clr_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (MemWrite)                  next_state = WRITE;
                else if (MemRead && !line_hit) next_state = FILL;
            end
            FILL:    if (mem_ack && last_beat) next_state = IDLE;
            WRITE:   if (mem_ack)              next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        hit      = is_idle && MemRead && !MemWrite && line_hit;
        readdata = hit ? rd_data : '0;
        stall    = (state == FILL) || (state == WRITE) ||
                   (is_idle && ((MemRead && !hit) || MemWrite));
        // Store hits update the cache in IDLE; fill beats land while in FILL.
        wr_en    = (is_idle && MemWrite && line_hit) || (state == FILL && mem_ack);
        wr_idx   = is_idle ? a_idx : m_idx;
        wr_off   = is_idle ? a_off : beat_cnt;
        wr_data  = is_idle ? datafrmreg : mem_rdata;
        clr_en   = is_idle && MemRead && !MemWrite && !line_hit;
        tag_en   = (state == FILL) && mem_ack && last_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWrite) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= aluRslt & ~ADDR_W'(3);
                        mem_wdata <= datafrmreg;
                    end else if (MemRead && !line_hit) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= aluRslt & ~ADDR_W'(4 * WPL - 1);
                        beat_cnt <= '0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                        if (last_beat) mem_req  <= 1'b0;
                        else           mem_addr <= mem_addr + ADDR_W'(4);
                    end
                end
                WRITE: if (mem_ack) mem_req <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
